fft_peak_detect: RTL
====================

Name: fft_peak_detect

Overview:
- Downstream consumer of the bit-reversal sorting stage of the 32-point FFT processor.
- Accepts the serialized natural-order spectrum on the `answer`/`seq` stream: 32 real words for bins 0..31, then 32 imaginary words for bins 0..31.
- Emits a per-bin power stream |X[k]|^2 = re^2 + im^2.
- Reports the peak bin and its power once per frame.

Parameters:
- W, 17, signed width of each incoming spectral word.
- N, 32, FFT points per frame (power of two); frame length is 2*N words.
- PW, 2*W, width of the power result (34 for W=17).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- seq  in  1  word-valid; high = `answer` carries a spectral word this cycle
- answer  in  W  signed spectral word (real words for bins 0..N-1, then imaginary words for bins 0..N-1)
- pow_out  out  PW  unsigned power of bin pow_idx
- pow_idx  out  log2(N)  bin index of pow_out
- pow_valid  out  1  pow_out/pow_idx valid this cycle
- peak_idx  out  log2(N)  bin with maximum power in the last completed frame
- peak_pow  out  PW  power of peak_idx
- done  out  1  one-cycle pulse: peak_idx/peak_pow just updated
- busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n=0 at a rising edge):
  - all outputs 0, state IDLE, word counter 0, running max 0.
  - Real-part buffer contents are don't-care.
  - A reset mid-frame discards the frame: no done pulse, and peak outputs go to 0.
- States: IDLE, LOAD_RE, PROC_IM.
  - IDLE: first cycle with seq=1 is real word of bin 0. Store it, counter=1, go to LOAD_RE.
  - LOAD_RE: each seq=1 cycle stores answer into re_buf[counter]. After bin N-1 is stored, counter wraps to 0 and state goes to PROC_IM.
  - PROC_IM: each seq=1 cycle takes im=answer and re=re_buf[counter], computes re*re + im*im and registers it.
  - PROC_IM, after bin N-1: go to LOAD_RE if seq is still asserted (back-to-back frames, no bubble needed), else IDLE. Next frame starts at real bin 0.
- Abort: seq=0 in LOAD_RE or PROC_IM (a gap) aborts the frame.
  - Return to IDLE, no done, peak outputs unchanged, counter cleared.
  - Gaps are not legal inside a frame.
- Arithmetic:
  - Signed W x W products; the sum is unsigned PW bits and cannot overflow. Max 2*(2^(W-1))^2 = 2^(2W-1) fits in 2W bits.
  - Example: re=im=-65536 gives 0x2_0000_0000.
- Power stream latency: pow_valid/pow_out/pow_idx are registered and appear exactly 1 cycle after the imaginary word is sampled. One pow_valid per imaginary word, indices 0..N-1 in order.
- Peak tracking:
  - Running max is reset to bin 0's power when bin 0 is processed.
  - Later bins replace it only if strictly greater, so on a tie the lowest index wins.
- Done: in the cycle that pow_valid is high for bin N-1, done=1 and peak_idx/peak_pow show the final frame result. They hold until the next done or reset.
- busy = (state != IDLE).

Test Plan:
- Reset then single frame: re[k]=k, im[k]=0, seq high 64 cycles.
  - pow_out sequence 0,1,4,...,961 at cycles 33..64 after the first word.
  - done with peak_idx=31, peak_pow=961.
- Single tone: re[5]=100, im[5]=-200, all else 0.
  - pow_out for bin 5 = 50000.
  - peak_idx=5, peak_pow=50000.
- Tie and extremes: re[3]=re[20]=-65536, im[3]=im[20]=-65536.
  - peak_idx=3, peak_pow=0x2_0000_0000; no overflow.
- Back-to-back frames (128 consecutive seq cycles, frame 2 peak at bin 9).
  - Two done pulses 64 cycles apart; second reports peak_idx=9.
  - No bin misalignment.
- Abort: seq drops at word 40, later a full frame is sent.
  - No done and no pow_valid beyond bin 7 for the aborted frame.
  - Next frame reports correctly.
- rst_n=0 for one cycle at word 50.
  - All outputs 0 next cycle, busy=0.
  - Following frame processed normally.

Source files
------------

// File: rtl/fft_peak_detect_if.sv
// Stream bundle between the bit-reversal sorter and the peak detector:
// spectral word input plus the power stream and per-frame peak report.
interface fft_peak_detect_if #(
  parameter int W  = 17,
  parameter int N  = 32,
  parameter int PW = 2 * W
);
  localparam int IW = $clog2(N);

  logic                 seq;
  logic signed [W-1:0]  answer;
  logic [PW-1:0]        pow_out;
  logic [IW-1:0]        pow_idx;
  logic                 pow_valid;
  logic [IW-1:0]        peak_idx;
  logic [PW-1:0]        peak_pow;
  logic                 done;
  logic                 busy;

  modport master (
    output seq, answer,
    input  pow_out, pow_idx, pow_valid, peak_idx, peak_pow, done, busy
  );

  modport slave (
    input  seq, answer,
    output pow_out, pow_idx, pow_valid, peak_idx, peak_pow, done, busy
  );
endinterface

// File: rtl/fft_peak_detect.sv
// Per-bin power |X[k]|^2 and per-frame peak search over a natural-order
// spectrum delivered as N real words followed by N imaginary words.
module fft_peak_detect #(
  parameter int W  = 17,
  parameter int N  = 32,
  parameter int PW = 2 * W
) (
  input  logic             clk,
  input  logic             rst_n,
  fft_peak_detect_if.slave bus
);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, LOAD_RE, PROC_IM} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        cnt_q, cnt_d;
  logic signed [W-1:0]  re_buf_q [N];
  logic                 buf_we;
  logic [PW-1:0]        cur_pow;
  logic [PW-1:0]        max_pow_q, max_pow_d;
  logic [IW-1:0]        max_idx_q, max_idx_d;
  logic [PW-1:0]        pow_out_q, pow_out_d;
  logic [IW-1:0]        pow_idx_q, pow_idx_d;
  logic                 pow_valid_q, pow_valid_d;
  logic [IW-1:0]        peak_idx_q, peak_idx_d;
  logic [PW-1:0]        peak_pow_q, peak_pow_d;
  logic                 done_q, done_d;

  // Both squares are non-negative and at most 2^(2W-2), so the sum fits PW bits.
  function automatic logic [PW-1:0] power(input logic signed [W-1:0] re,
                                          input logic signed [W-1:0] im);
    logic signed [PW-1:0] rr;
    logic signed [PW-1:0] ii;
    rr = PW'(re) * PW'(re);
    ii = PW'(im) * PW'(im);
    return $unsigned(rr) + $unsigned(ii);
  endfunction

  assign cur_pow = power(re_buf_q[cnt_q], bus.answer);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_we      = 1'b0;
    max_pow_d   = max_pow_q;
    max_idx_d   = max_idx_q;
    pow_out_d   = pow_out_q;
    pow_idx_d   = pow_idx_q;
    pow_valid_d = 1'b0;
    peak_idx_d  = peak_idx_q;
    peak_pow_d  = peak_pow_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.seq) begin
          buf_we  = 1'b1;
          cnt_d   = IW'(1);
          state_d = LOAD_RE;
        end
      end
      LOAD_RE: begin
        if (!bus.seq) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + IW'(1);
          if (cnt_q == IW'(N - 1)) state_d = PROC_IM;
        end
      end
      PROC_IM: begin
        if (!bus.seq) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          pow_valid_d = 1'b1;
          pow_out_d   = cur_pow;
          pow_idx_d   = cnt_q;
          cnt_d       = cnt_q + IW'(1);
          // Strictly-greater update keeps the lowest index on ties.
          if (cnt_q == '0 || cur_pow > max_pow_q) begin
            max_pow_d = cur_pow;
            max_idx_d = cnt_q;
          end
          if (cnt_q == IW'(N - 1)) begin
            done_d     = 1'b1;
            peak_idx_d = max_idx_d;
            peak_pow_d = max_pow_d;
            state_d    = LOAD_RE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      max_pow_q   <= '0;
      max_idx_q   <= '0;
      pow_out_q   <= '0;
      pow_idx_q   <= '0;
      pow_valid_q <= 1'b0;
      peak_idx_q  <= '0;
      peak_pow_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      max_pow_q   <= max_pow_d;
      max_idx_q   <= max_idx_d;
      pow_out_q   <= pow_out_d;
      pow_idx_q   <= pow_idx_d;
      pow_valid_q <= pow_valid_d;
      peak_idx_q  <= peak_idx_d;
      peak_pow_q  <= peak_pow_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) re_buf_q[cnt_q] <= bus.answer;
  end

  assign bus.pow_out   = pow_out_q;
  assign bus.pow_idx   = pow_idx_q;
  assign bus.pow_valid = pow_valid_q;
  assign bus.peak_idx  = peak_idx_q;
  assign bus.peak_pow  = peak_pow_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
